// File: rtl/oned_conv_pkg.sv
// Shared types and helpers for the oned_conv engine: FSM states, accumulator
// width and the saturating reduction used when ONEDCONV_SAT_EN is defined.
package oned_conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  localparam int DW_DEF = 16;
  localparam int ACC_W  = 2 * DW_DEF + 10;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW_DEF - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW_DEF - 1)));

  function automatic logic [DW_DEF-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] clamped;
    clamped = acc;
    if (acc > SAT_MAX)
      clamped = SAT_MAX;
    else if (acc < SAT_MIN)
      clamped = SAT_MIN;
    return DW_DEF'(clamped);
  endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Multi-bank simple dual-port RAM: port A writes, port B reads with one cycle
// of latency; each bank's read register holds its value while its enable is low.
module conv_bank_ram #(
  parameter int DW    = 16,
  parameter int NB    = 16,
  parameter int AW    = 13,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NB-1:0]    ena,
  input  logic [NB-1:0]    wea,
  input  logic [AW-1:0]    addra,
  input  logic [DW*NB-1:0] dina,
  input  logic [NB-1:0]    enb,
  input  logic [AW-1:0]    addrb,
  output logic [DW*NB-1:0] doutb
);

  localparam int DAW = $clog2(DEPTH);

  logic [DW-1:0] mem [NB][DEPTH];
  logic          addr_hi_unused;

  assign addr_hi_unused = ^{addra[AW-1:DAW], addrb[AW-1:DAW]};

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (ena[b] && wea[b])
        mem[b][addra[DAW-1:0]] <= dina[b*DW +: DW];
  end

  // Storage array is never reset; only the read registers are.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      doutb <= '0;
    else
      for (int b = 0; b < NB; b++)
        if (enb[b])
          doutb[b*DW +: DW] <= mem[b][addrb[DAW-1:0]];
  end

endmodule

// File: rtl/oned_conv.sv
// Sequential 1-D convolution engine, one MAC per cycle, banked input/weight/result
// memories. Define ONEDCONV_SAT_EN to saturate results instead of wrapping.
module oned_conv
  import oned_conv_pkg::*;
#(
  parameter int DW             = 16,
  parameter int Dimension      = 16,
  parameter int ADDRESS_LENGTH = 13,
  parameter int BRAM_Depth     = 512,
  parameter int MAX_COUNT      = 512,
  parameter int MUX_SEL_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_whole,
  input  logic [1:0]                stride,
  input  logic [2:0]                padding,
  input  logic [4:0]                kernel_size,
  input  logic [9:0]                input_channels,
  input  logic [9:0]                temporal_length,
  input  logic [9:0]                filter_number,
  input  logic [Dimension-1:0]      ena_weight_input_bram,
  input  logic [Dimension-1:0]      wea_weight_input_bram,
  input  logic [Dimension-1:0]      ena_inputdata_input_bram,
  input  logic [Dimension-1:0]      wea_inputdata_input_bram,
  input  logic [ADDRESS_LENGTH-1:0] weight_bram_addr,
  input  logic [ADDRESS_LENGTH-1:0] inputdata_bram_addr,
  input  logic [DW*Dimension-1:0]   weight_input_bram,
  input  logic [DW*Dimension-1:0]   inputdata_input_bram,
  input  logic                      read_mode_output_result,
  input  logic [Dimension-1:0]      enb_output_result,
  input  logic [ADDRESS_LENGTH-1:0] output_result_bram_addr,
  output logic                      done_all,
  output logic [DW*Dimension-1:0]   output_result
);

  localparam int CW = $clog2(MAX_COUNT) + 2;
  localparam int NB = Dimension;
  localparam int AL = ADDRESS_LENGTH;

  state_t state, state_nx;

  logic [2:0]    s_r, p_r;
  logic [4:0]    k_r, k_cnt;
  logic [9:0]    c_r, t_r, f_r, g_r, f_cnt, ch_cnt;
  logic [CW-1:0] l_r, o_cnt;
  logic          empty_r, taps_done, drain, go;

  logic [15:0] span, reach, l_div, t_pos;
  logic        no_work, in_range, issue, rd_en, last_tap, last_out, last_filter;

  logic [AL-1:0]             in_addr, w_addr, res_addr;
  logic [NB-1:0]             rd_bank, wr_bank, res_rd_en;
  logic [DW*NB-1:0]          in_dout, w_dout;
  logic [MUX_SEL_WIDTH-1:0]  bank_q;
  logic                      v1, v2;
  logic signed [DW-1:0]      x_lane, w_lane;
  logic signed [2*DW-1:0]    prod_q;
  logic signed [ACC_W-1:0]   acc;
  logic [DW-1:0]             res;

  assign go = start_whole && (state == IDLE || state == DONE);

  // Output length: floor((T+2P-K)/S)+1, with empty runs when nothing fits.
  assign span    = 16'(temporal_length) + 16'({padding, 1'b0});
  assign reach   = span - 16'(kernel_size);
  assign no_work = (kernel_size == 5'd0) || (span < 16'(kernel_size)) ||
                   (input_channels == 10'd0) || (filter_number == 10'd0);

  always_comb begin
    case (stride)
      2'd0:    l_div = reach;
      2'd1:    l_div = reach >> 1;
      2'd2:    l_div = reach / 16'd3;
      default: l_div = reach >> 2;
    endcase
  end

  assign t_pos       = 16'(o_cnt) * 16'(s_r) + 16'(k_cnt) - 16'(p_r);
  assign in_range    = !t_pos[15] && (t_pos < 16'(t_r));
  assign issue       = (state == RUN) && !empty_r && !taps_done;
  assign rd_en       = issue && in_range;
  assign last_tap    = (ch_cnt == c_r - 10'd1) && (k_cnt == k_r - 5'd1);
  assign last_out    = (o_cnt == l_r - CW'(1));
  assign last_filter = (f_cnt == f_r - 10'd1);

  assign in_addr  = AL'(16'(ch_cnt >> MUX_SEL_WIDTH) * 16'(t_r) + t_pos);
  assign w_addr   = AL'((16'(f_cnt) * 16'(g_r) + 16'(ch_cnt >> MUX_SEL_WIDTH)) * 16'(k_r)
                        + 16'(k_cnt));
  assign res_addr = AL'(16'(f_cnt >> MUX_SEL_WIDTH) * 16'(l_r) + 16'(o_cnt));

  assign rd_bank   = rd_en ? (NB'(1) << ch_cnt[MUX_SEL_WIDTH-1:0]) : '0;
  assign wr_bank   = (state == WRITE) ? (NB'(1) << f_cnt[MUX_SEL_WIDTH-1:0]) : '0;
  assign res_rd_en = read_mode_output_result ? enb_output_result : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_whole) state_nx = RUN;
      RUN:     if (empty_r) state_nx = DONE;
               else if (taps_done && drain) state_nx = WRITE;
      WRITE:   state_nx = (last_out && last_filter) ? DONE : RUN;
      DONE:    if (start_whole) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Loop counters: k innermost, then channel; o and f advance on each write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r <= '0; p_r <= '0; k_r <= '0; c_r <= '0; t_r <= '0; f_r <= '0;
      g_r <= '0; l_r <= '0; empty_r <= 1'b0;
      f_cnt <= '0; o_cnt <= '0; ch_cnt <= '0; k_cnt <= '0;
      taps_done <= 1'b0; drain <= 1'b0;
    end else if (go) begin
      s_r     <= 3'(stride) + 3'd1;
      p_r     <= padding;
      k_r     <= kernel_size;
      c_r     <= input_channels;
      t_r     <= temporal_length;
      f_r     <= filter_number;
      g_r     <= 10'((11'(input_channels) + 11'(Dimension - 1)) >> MUX_SEL_WIDTH);
      l_r     <= no_work ? '0 : CW'(l_div + 16'd1);
      empty_r <= no_work;
      f_cnt <= '0; o_cnt <= '0; ch_cnt <= '0; k_cnt <= '0;
      taps_done <= 1'b0; drain <= 1'b0;
    end else begin
      case (state)
        RUN: if (!empty_r) begin
          if (!taps_done) begin
            if (last_tap) begin
              taps_done <= 1'b1;
              ch_cnt    <= '0;
              k_cnt     <= '0;
            end else if (k_cnt == k_r - 5'd1) begin
              k_cnt  <= '0;
              ch_cnt <= ch_cnt + 10'd1;
            end else begin
              k_cnt <= k_cnt + 5'd1;
            end
          end else begin
            drain <= 1'b1;
          end
        end
        WRITE: begin
          taps_done <= 1'b0;
          drain     <= 1'b0;
          if (last_out) begin
            o_cnt <= '0;
            f_cnt <= f_cnt + 10'd1;
          end else begin
            o_cnt <= o_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign x_lane = in_dout[int'(bank_q)*DW +: DW];
  assign w_lane = w_dout[int'(bank_q)*DW +: DW];

  // Address -> RAM read -> registered product -> accumulate; padded taps carry v=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; v2 <= 1'b0; bank_q <= '0; prod_q <= '0; acc <= '0;
    end else begin
      v1     <= rd_en;
      v2     <= v1;
      bank_q <= ch_cnt[MUX_SEL_WIDTH-1:0];
      prod_q <= (2*DW)'(x_lane) * (2*DW)'(w_lane);
      if (go || state == WRITE)
        acc <= '0;
      else if (v2)
        acc <= acc + ACC_W'(prod_q);
    end
  end

`ifdef ONEDCONV_SAT_EN
  assign res = saturate(acc);
`else
  assign res = acc[DW-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      done_all <= 1'b0;
    else
      done_all <= (state_nx == DONE);
  end

  conv_bank_ram #(.DW(DW), .NB(NB), .AW(AL), .DEPTH(BRAM_Depth)) u_input_ram (
    .clk(clk), .rst(rst),
    .ena(ena_inputdata_input_bram), .wea(wea_inputdata_input_bram),
    .addra(inputdata_bram_addr), .dina(inputdata_input_bram),
    .enb(rd_bank), .addrb(in_addr), .doutb(in_dout)
  );

  conv_bank_ram #(.DW(DW), .NB(NB), .AW(AL), .DEPTH(BRAM_Depth)) u_weight_ram (
    .clk(clk), .rst(rst),
    .ena(ena_weight_input_bram), .wea(wea_weight_input_bram),
    .addra(weight_bram_addr), .dina(weight_input_bram),
    .enb(rd_bank), .addrb(w_addr), .doutb(w_dout)
  );

  conv_bank_ram #(.DW(DW), .NB(NB), .AW(AL), .DEPTH(BRAM_Depth)) u_result_ram (
    .clk(clk), .rst(rst),
    .ena(wr_bank), .wea(wr_bank),
    .addra(res_addr), .dina({NB{res}}),
    .enb(res_rd_en), .addrb(output_result_bram_addr), .doutb(output_result)
  );

endmodule

// File: tb/tb_oned_conv.sv
// Scoreboard bench for oned_conv: directed convolution cases with hand-computed
// results; readback expectations are queued and checked by a separate monitor.
module tb_oned_conv;

  localparam int DW = 16;
  localparam int NB = 16;
  localparam int AL = 13;

`ifdef ONEDCONV_SAT_EN
  localparam int SAT_EXP = 32'h7FFF;
`else
  localparam int SAT_EXP = 32'h0003;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start_whole;
  logic [1:0] stride;
  logic [2:0] padding;
  logic [4:0] kernel_size;
  logic [9:0] input_channels, temporal_length, filter_number;
  logic [NB-1:0] ena_weight_input_bram, wea_weight_input_bram;
  logic [NB-1:0] ena_inputdata_input_bram, wea_inputdata_input_bram;
  logic [AL-1:0] weight_bram_addr, inputdata_bram_addr;
  logic [DW*NB-1:0] weight_input_bram, inputdata_input_bram;
  logic read_mode_output_result;
  logic [NB-1:0] enb_output_result;
  logic [AL-1:0] output_result_bram_addr;
  logic done_all;
  logic [DW*NB-1:0] output_result;

  int checks = 0;
  int errors = 0;

  int    exp_q[$];
  int    lane_q[$];
  string name_q[$];
  logic  rd_issue = 1'b0;
  logic  rd_q = 1'b0;

  oned_conv dut (
    .clk(clk), .rst(rst), .start_whole(start_whole),
    .stride(stride), .padding(padding), .kernel_size(kernel_size),
    .input_channels(input_channels), .temporal_length(temporal_length),
    .filter_number(filter_number),
    .ena_weight_input_bram(ena_weight_input_bram), .wea_weight_input_bram(wea_weight_input_bram),
    .ena_inputdata_input_bram(ena_inputdata_input_bram),
    .wea_inputdata_input_bram(wea_inputdata_input_bram),
    .weight_bram_addr(weight_bram_addr), .inputdata_bram_addr(inputdata_bram_addr),
    .weight_input_bram(weight_input_bram), .inputdata_input_bram(inputdata_input_bram),
    .read_mode_output_result(read_mode_output_result),
    .enb_output_result(enb_output_result),
    .output_result_bram_addr(output_result_bram_addr),
    .done_all(done_all), .output_result(output_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_q <= rd_issue;

  // Monitor: a read issued last cycle presents its data now.
  always @(negedge clk) begin : monitor
    int    want, got, ln;
    string nm;
    if (rd_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_underflow: got a readback with no expected entry");
      end else begin
        want = exp_q.pop_front();
        ln   = lane_q.pop_front();
        nm   = name_q.pop_front();
        got  = int'(output_result[ln*DW +: DW]);
        if (got != want) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", nm, got, want);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic writeMem(input int which, input int bank, input int addr, input int val);
    if (which == 0) begin
      ena_inputdata_input_bram = NB'(1) << bank;
      wea_inputdata_input_bram = NB'(1) << bank;
      inputdata_bram_addr      = AL'(addr);
      inputdata_input_bram     = '0;
      inputdata_input_bram[bank*DW +: DW] = 16'(val);
    end else begin
      ena_weight_input_bram = NB'(1) << bank;
      wea_weight_input_bram = NB'(1) << bank;
      weight_bram_addr      = AL'(addr);
      weight_input_bram     = '0;
      weight_input_bram[bank*DW +: DW] = 16'(val);
    end
    @(posedge clk); #1;
    ena_inputdata_input_bram = '0; wea_inputdata_input_bram = '0;
    ena_weight_input_bram    = '0; wea_weight_input_bram    = '0;
  endtask

  task automatic loadCase1();
    for (int t = 0; t < 16; t++) writeMem(0, 0, t, t);
    for (int k = 0; k < 3; k++) writeMem(1, 0, k, k + 1);
  endtask

  task automatic applyStimulus(input int st, input int pd, input int ks,
                               input int c, input int t, input int f);
    read_mode_output_result = 1'b0;
    stride          = 2'(st);
    padding         = 3'(pd);
    kernel_size     = 5'(ks);
    input_channels  = 10'(c);
    temporal_length = 10'(t);
    filter_number   = 10'(f);
    start_whole     = 1'b1;
    @(posedge clk); #1;
    start_whole = 1'b0;
    checkOutput("done_low_after_start", int'(done_all), 0);
  endtask

  task automatic waitDone(input string name, input int lo, input int hi);
    int cyc = 0;
    while (!done_all && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_all) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: done_all never rose, expected within %0d cycles", name, hi);
    end else begin
      checkRange(name, cyc, lo, hi);
    end
  endtask

  task automatic readResult(input int bank, input int addr, input int expv, input string name);
    exp_q.push_back(expv);
    lane_q.push_back(bank);
    name_q.push_back(name);
    read_mode_output_result = 1'b1;
    enb_output_result       = NB'(1) << bank;
    output_result_bram_addr = AL'(addr);
    rd_issue                = 1'b1;
    @(posedge clk); #1;
    enb_output_result = '0;
    rd_issue          = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start_whole = 1'b0; stride = '0; padding = '0; kernel_size = '0;
    input_channels = '0; temporal_length = '0; filter_number = '0;
    ena_weight_input_bram = '0; wea_weight_input_bram = '0;
    ena_inputdata_input_bram = '0; wea_inputdata_input_bram = '0;
    weight_bram_addr = '0; inputdata_bram_addr = '0;
    weight_input_bram = '0; inputdata_input_bram = '0;
    read_mode_output_result = 1'b0; enb_output_result = '0; output_result_bram_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_done", int'(done_all), 0);
    checkOutput("reset_out_zero", int'(|output_result), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] case 1: C=1 T=16 K=3 S=1 P=0");
    loadCase1();
    applyStimulus(0, 0, 3, 1, 16, 1);
    waitDone("c1_latency", 84, 86);
    readResult(0, 0, 8, "c1_y0");
    readResult(0, 1, 14, "c1_y1");
    readResult(0, 13, 86, "c1_y13");
    readResult(0, 7, 50, "c1_y7");
    output_result_bram_addr = AL'(0);
    @(posedge clk); #1;
    checkOutput("c1_hold", int'(output_result[DW-1:0]), 50);

    $display("[TB] case 2: stride 2");
    applyStimulus(1, 0, 3, 1, 16, 1);
    waitDone("c2_latency", 42, 44);
    readResult(0, 0, 8, "c2_y0");
    readResult(0, 3, 44, "c2_y3");
    readResult(0, 6, 80, "c2_y6");

    $display("[TB] case 3: padding 2");
    applyStimulus(0, 2, 3, 1, 16, 1);
    waitDone("c3_latency", 108, 110);
    readResult(0, 0, 0, "c3_y0");
    readResult(0, 1, 3, "c3_y1");
    readResult(0, 2, 8, "c3_y2");
    readResult(0, 16, 44, "c3_y16");
    readResult(0, 17, 15, "c3_y17");

    $display("[TB] case L=0: T=2 K=3");
    applyStimulus(0, 0, 3, 1, 2, 1);
    waitDone("l0_done", 1, 2);

    $display("[TB] case 4: C=4 F=2");
    for (int ch = 0; ch < 4; ch++)
      for (int t = 0; t < 16; t++) writeMem(0, ch, t, 100 * ch + t);
    for (int ch = 0; ch < 4; ch++)
      for (int k = 0; k < 3; k++) begin
        writeMem(1, ch, k, k + 1);
        writeMem(1, ch, 3 + k, 2 * (k + 1));
      end
    applyStimulus(0, 0, 3, 4, 16, 2);
    waitDone("c4_latency", 420, 422);
    readResult(0, 0, 3632, "c4_f0_y0");
    readResult(0, 13, 3944, "c4_f0_y13");
    readResult(1, 0, 7264, "c4_f1_y0");
    readResult(1, 5, 7504, "c4_f1_y5");

    $display("[TB] case 5: full-scale products");
    for (int t = 0; t < 3; t++) writeMem(0, 0, t, 32767);
    for (int k = 0; k < 3; k++) writeMem(1, 0, k, 32767);
    applyStimulus(0, 0, 3, 1, 3, 1);
    waitDone("c5_latency", 6, 8);
    readResult(0, 0, SAT_EXP, "c5_reduce");

    $display("[TB] case 6: start while busy");
    loadCase1();
    applyStimulus(0, 0, 3, 1, 16, 1);
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("busy_done_low", int'(done_all), 0);
    stride = 2'd1;
    start_whole = 1'b1;
    @(posedge clk); #1;
    start_whole = 1'b0;
    waitDone("busy_latency", 73, 75);
    readResult(0, 1, 14, "busy_y1");
    readResult(0, 13, 86, "busy_y13");

    $display("[TB] case 7: reset mid-run");
    applyStimulus(0, 0, 3, 1, 16, 1);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b0;
    #2;
    checkOutput("rst_abort_done", int'(done_all), 0);
    checkOutput("rst_abort_out", int'(|output_result), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 0, 3, 1, 16, 1);
    waitDone("rerun_latency", 84, 86);
    readResult(0, 0, 8, "rerun_y0");
    readResult(0, 5, 38, "rerun_y5");
    readResult(0, 13, 86, "rerun_y13");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
